lcd_req_arbiter: RTL

Shares the single LCD custom controller between two command sources. Port A is the mini CPU; port B is an auxiliary source such as a status or debug reporter. Each port has its own small command FIFO. A round-robin scheduler issues one command at a time to the LCD controller and sequences the update_req/busy handshake. The block sits between the requesters and the LCD controller's update_req, opcode_in, reg_idx_in, value_in and busy pins.

---
 rtl/lcd_req_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_req_arbiter.sv
// Two-port round-robin arbiter sharing one LCD controller (port A = mini CPU, port B = aux).
// Define LCD_ARB_STATS_EN to add a_done_cnt_o/b_done_cnt_o/to_cnt_o saturating counters.

module lcd_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         ready_o,
  output logic         nempty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         full, push, nempty_q;

  assign full     = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign ready_o  = ~full & ~rst_i;
  assign push     = valid_i & ready_o;
  assign head_o   = mem_q[rd_q[AW-1:0]];
  assign nempty_o = nempty_q;

  // Non-empty is seen by the scheduler one cycle late; a pop is always followed by
  // at least two non-IDLE cycles, so the lag can never expose an empty head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q     <= '0;
      rd_q     <= '0;
      nempty_q <= 1'b0;
    end else begin
      if (push)  wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      nempty_q <= (wr_q != rd_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

module lcd_req_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [2:0]  a_opcode_i,
  input  logic [3:0]  a_reg_idx_i,
  input  logic [15:0] a_value_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic [2:0]  b_opcode_i,
  input  logic [3:0]  b_reg_idx_i,
  input  logic [15:0] b_value_i,
  output logic        lcd_update_o,
  output logic [2:0]  lcd_opcode_o,
  output logic [3:0]  lcd_reg_idx_o,
  output logic [15:0] lcd_value_o,
  input  logic        lcd_busy_i,
  output logic        grant_b_o,
  output logic        timeout_err_o
`ifdef LCD_ARB_STATS_EN
  ,
  output logic [7:0]  a_done_cnt_o,
  output logic [7:0]  b_done_cnt_o,
  output logic [7:0]  to_cnt_o
`endif
);
  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  idx;
    logic [15:0] val;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RISE, WAIT_FALL} state_t;

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rr_q, rr_d;       // last completed port; reset to B so A wins first tie
  logic          grant_q, grant_d;
  cmd_t          out_q, out_d;
  cmd_t          a_head, b_head;
  logic          a_ne, b_ne, pop_a, pop_b, timeout, done;

  lcd_req_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (a_valid_i),
    .data_i   ({a_opcode_i, a_reg_idx_i, a_value_i}),
    .pop_i    (pop_a),
    .ready_o  (a_ready_o),
    .nempty_o (a_ne),
    .head_o   (a_head)
  );

  lcd_req_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (b_valid_i),
    .data_i   ({b_opcode_i, b_reg_idx_i, b_value_i}),
    .pop_i    (pop_b),
    .ready_o  (b_ready_o),
    .nempty_o (b_ne),
    .head_o   (b_head)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    out_d   = out_q;
    pop_a   = 1'b0;
    pop_b   = 1'b0;
    timeout = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lcd_busy_i && (a_ne || b_ne)) begin
          if (b_ne && (!a_ne || !rr_q)) begin
            pop_b   = 1'b1;
            grant_d = 1'b1;
            out_d   = b_head;
          end else begin
            pop_a   = 1'b1;
            grant_d = 1'b0;
            out_d   = a_head;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (lcd_busy_i) begin
          state_d = WAIT_FALL;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!lcd_busy_i) begin
          done    = 1'b1;
          rr_d    = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      rr_q    <= 1'b1;
      grant_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      out_q   <= out_d;
    end
  end

  assign lcd_update_o  = (state_q == ISSUE);
  assign lcd_opcode_o  = out_q.op;
  assign lcd_reg_idx_o = out_q.idx;
  assign lcd_value_o   = out_q.val;
  assign grant_b_o     = grant_q;
  assign timeout_err_o = timeout;

`ifdef LCD_ARB_STATS_EN
  logic [7:0] a_cnt_q, b_cnt_q, to_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      if (done && !grant_q && a_cnt_q != 8'hFF) a_cnt_q <= a_cnt_q + 1'b1;
      if (done &&  grant_q && b_cnt_q != 8'hFF) b_cnt_q <= b_cnt_q + 1'b1;
      if (timeout && to_cnt_q != 8'hFF)         to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign a_done_cnt_o = a_cnt_q;
  assign b_done_cnt_o = b_cnt_q;
  assign to_cnt_o     = to_cnt_q;
`endif
endmodule
